// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared store size encodings and store FSM state type
package core_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } store_state_e;

endpackage

// File: rtl/core_store_align.sv
// rtl/core_store_align.sv - sizes store data and shifts data/byte mask into lane position
module core_store_align
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]        addr_i,
   input  logic [1:0]        size_i,
   input  logic [XLEN-1:0]   data_i,
   output logic [2*XLEN-1:0] shift_data_o,
   output logic [7:0]        shift_mask_o
);

   logic [3:0]      base_mask;
   logic [XLEN-1:0] masked_data;

   // Size 2'b10 is not a legal encoding and falls through to word.
   always_comb begin
      base_mask   = 4'b1111;
      masked_data = data_i;
      case (size_i)
         SIZE_BYTE: begin
            base_mask   = 4'b0001;
            masked_data = {{(XLEN-8){1'b0}}, data_i[7:0]};
         end
         SIZE_HALF: begin
            base_mask   = 4'b0011;
            masked_data = {{(XLEN-16){1'b0}}, data_i[15:0]};
         end
         default: begin
            base_mask   = 4'b1111;
            masked_data = data_i;
         end
      endcase
   end

   assign shift_data_o = {{XLEN{1'b0}}, masked_data} << {addr_i, 3'b000};
   assign shift_mask_o = {4'b0000, base_mask} << addr_i;

endmodule

// File: rtl/core_store_unit.sv
// rtl/core_store_unit.sv - store FSM issuing one or two aligned word writes per store
module core_store_unit
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_st_valid,
   output logic            o_st_ready,
   input  logic [XLEN-1:0] i_st_addr,
   input  logic [XLEN-1:0] i_st_data,
   input  logic [1:0]      i_st_size,
   output logic            o_busy,
   output logic            o_st_done,
   output logic            o_dmem_req,
   input  logic            i_dmem_gnt,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [XLEN-1:0] o_dmem_wdata,
   output logic [3:0]      o_dmem_be
);

   store_state_e    state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            done_q, done_d;
   logic [XLEN-1:0] hi_data_q, hi_data_d;
   logic [3:0]      hi_be_q, hi_be_d;
   logic            split_q, split_d;

   logic [2*XLEN-1:0] shift_data;
   logic [7:0]        shift_mask;

   core_store_align #(.XLEN(XLEN)) u_align (
      .addr_i       (i_st_addr[1:0]),
      .size_i       (i_st_size),
      .data_i       (i_st_data),
      .shift_data_o (shift_data),
      .shift_mask_o (shift_mask)
   );

   // req_q is high in FIRST/SECOND, so gnt alone marks beat completion there.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      done_d    = 1'b0;
      hi_data_d = hi_data_q;
      hi_be_d   = hi_be_q;
      split_d   = split_q;
      case (state_q)
         ST_IDLE: begin
            if (i_st_valid) begin
               state_d   = ST_FIRST;
               req_d     = 1'b1;
               addr_d    = {i_st_addr[XLEN-1:2], 2'b00};
               wdata_d   = shift_data[XLEN-1:0];
               be_d      = shift_mask[3:0];
               hi_data_d = shift_data[2*XLEN-1:XLEN];
               hi_be_d   = shift_mask[7:4];
               split_d   = |shift_mask[7:4];
            end
         end
         ST_FIRST: begin
            if (i_dmem_gnt) begin
               if (split_q) begin
                  state_d = ST_SECOND;
                  addr_d  = addr_q + XLEN'(4);
                  wdata_d = hi_data_q;
                  be_d    = hi_be_q;
               end else begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
                  be_d    = 4'b0000;
                  done_d  = 1'b1;
               end
            end
         end
         ST_SECOND: begin
            if (i_dmem_gnt) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               be_d    = 4'b0000;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            be_d    = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= 4'b0000;
         done_q    <= 1'b0;
         hi_data_q <= '0;
         hi_be_q   <= 4'b0000;
         split_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         done_q    <= done_d;
         hi_data_q <= hi_data_d;
         hi_be_q   <= hi_be_d;
         split_q   <= split_d;
      end
   end

   assign o_st_ready   = (state_q == ST_IDLE);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_st_done    = done_q;
   assign o_dmem_req   = req_q;
   assign o_dmem_we    = req_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_be    = be_q;

endmodule

// File: tb/tb_core_store_unit.sv
// tb/tb_core_store_unit.sv - directed self-checking bench for core_store_unit
module tb_core_store_unit;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic        busy;
   logic        st_done;
   logic        dmem_req;
   logic        dmem_gnt;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;

   int errors = 0;
   int checks = 0;

   core_store_unit dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_st_valid   (st_valid),
      .o_st_ready   (st_ready),
      .i_st_addr    (st_addr),
      .i_st_data    (st_data),
      .i_st_size    (st_size),
      .o_busy       (busy),
      .o_st_done    (st_done),
      .o_dmem_req   (dmem_req),
      .i_dmem_gnt   (dmem_gnt),
      .o_dmem_we    (dmem_we),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_wdata (dmem_wdata),
      .o_dmem_be    (dmem_be)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: {req, we, addr, be, wdata, done, ready, busy}
   function automatic logic [72:0] obs();
      return {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, st_done, st_ready, busy};
   endfunction

   // Drives a one-cycle store request; returns at the negedge after the accepting posedge.
   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_size  = s;
      @(negedge clk);
      st_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b00; dmem_gnt = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (obs() !== {1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state actual=%h required=%h", obs(), {1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      end
      @(negedge clk);
   endtask

   task automatic test_word_aligned();
      dmem_gnt = 1'b1;
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL word_ready_before actual=%b required=1", st_ready); end
      drive_store(32'h0000_1000, 32'h1122_3344, 2'b11);
      checks++;
      if (obs() !== {1'b1, 1'b1, 32'h1000, 4'b1111, 32'h1122_3344, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL word_beat actual=%h required=%h", obs(), {1'b1, 1'b1, 32'h1000, 4'b1111, 32'h1122_3344, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_be, st_done, st_ready, busy} !== {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL word_done actual=%b required=%b", {dmem_req, dmem_be, st_done, st_ready, busy}, {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      end
      @(negedge clk);
      checks++;
      if (st_done !== 1'b0) begin errors++; $display("FAIL word_done_pulse actual=%b required=0", st_done); end
   endtask

   task automatic test_byte();
      dmem_gnt = 1'b1;
      drive_store(32'h0000_1003, 32'hDEAD_BEAB, 2'b00);
      checks++;
      if (obs() !== {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL byte_beat actual=%h required=%h", obs(), {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
      checks++;
      if ({dmem_req, st_done} !== 2'b01) begin errors++; $display("FAIL byte_done actual=%b required=01", {dmem_req, st_done}); end
      @(negedge clk);
   endtask

   task automatic test_half_split();
      dmem_gnt = 1'b1;
      drive_store(32'h0000_2003, 32'h0000_BEEF, 2'b01);
      checks++;
      if (obs() !== {1'b1, 1'b1, 32'h2000, 4'b1000, 32'hEF00_0000, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL half_beat0 actual=%h required=%h", obs(), {1'b1, 1'b1, 32'h2000, 4'b1000, 32'hEF00_0000, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
      checks++;
      if (obs() !== {1'b1, 1'b1, 32'h2004, 4'b0001, 32'h0000_00BE, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL half_beat1 actual=%h required=%h", obs(), {1'b1, 1'b1, 32'h2004, 4'b0001, 32'h0000_00BE, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
      checks++;
      if ({dmem_req, st_done, st_ready} !== 3'b011) begin errors++; $display("FAIL half_done actual=%b required=011", {dmem_req, st_done, st_ready}); end
      @(negedge clk);
      checks++;
      if (st_done !== 1'b0) begin errors++; $display("FAIL half_single_done actual=%b required=0", st_done); end
   endtask

   task automatic test_stall_split();
      dmem_gnt = 1'b0;
      drive_store(32'h0000_3001, 32'h1122_3344, 2'b11);
      for (int i = 0; i < 4; i++) begin
         dmem_gnt = (i == 3);
         checks++;
         if (obs() !== {1'b1, 1'b1, 32'h3000, 4'b1110, 32'h2233_4400, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL stall_beat0_%0d actual=%h required=%h", i, obs(), {1'b1, 1'b1, 32'h3000, 4'b1110, 32'h2233_4400, 1'b0, 1'b0, 1'b1});
         end
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         dmem_gnt = (i == 3);
         checks++;
         if (obs() !== {1'b1, 1'b1, 32'h3004, 4'b0001, 32'h0000_0011, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL stall_beat1_%0d actual=%h required=%h", i, obs(), {1'b1, 1'b1, 32'h3004, 4'b0001, 32'h0000_0011, 1'b0, 1'b0, 1'b1});
         end
         @(negedge clk);
      end
      dmem_gnt = 1'b0;
      checks++;
      if ({dmem_req, st_done, st_ready} !== 3'b011) begin errors++; $display("FAIL stall_done actual=%b required=011", {dmem_req, st_done, st_ready}); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      dmem_gnt = 1'b1;
      drive_store(32'hFFFF_FFFF, 32'h0000_CAFE, 2'b01);
      checks++;
      if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hFE00_0000}) begin
         errors++; $display("FAIL wrap_beat0 actual=%h required=%h", {dmem_req, dmem_addr, dmem_be, dmem_wdata}, {1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hFE00_0000});
      end
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00CA}) begin
         errors++; $display("FAIL wrap_beat1 actual=%h required=%h", {dmem_req, dmem_addr, dmem_be, dmem_wdata}, {1'b1, 32'h0000_0000, 4'b0001, 32'h0000_00CA});
      end
      @(negedge clk);
      checks++;
      if (st_done !== 1'b1) begin errors++; $display("FAIL wrap_done actual=%b required=1", st_done); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      dmem_gnt = 1'b1;
      drive_store(32'h0000_0010, 32'hA5A5_A5A5, 2'b10);
      checks++;
      if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'h0000_0010, 4'b1111, 32'hA5A5_A5A5}) begin
         errors++; $display("FAIL b2b_first actual=%h required=%h", {dmem_req, dmem_addr, dmem_be, dmem_wdata}, {1'b1, 32'h0000_0010, 4'b1111, 32'hA5A5_A5A5});
      end
      @(negedge clk);
      checks++;
      if ({st_done, st_ready} !== 2'b11) begin errors++; $display("FAIL b2b_done_ready actual=%b required=11", {st_done, st_ready}); end
      drive_store(32'h0000_0021, 32'h1234_567F, 2'b00);
      checks++;
      if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, st_done} !== {1'b1, 32'h0000_0020, 4'b0010, 32'h0000_7F00, 1'b0}) begin
         errors++; $display("FAIL b2b_second actual=%h required=%h", {dmem_req, dmem_addr, dmem_be, dmem_wdata, st_done}, {1'b1, 32'h0000_0020, 4'b0010, 32'h0000_7F00, 1'b0});
      end
      @(negedge clk);
      checks++;
      if (st_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done actual=%b required=1", st_done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      dmem_gnt = 1'b1;
      drive_store(32'h0000_2003, 32'h0000_BEEF, 2'b01);
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_addr} !== {1'b1, 32'h0000_2004}) begin
         errors++; $display("FAIL rst_mid_in_second actual=%h required=%h", {dmem_req, dmem_addr}, {1'b1, 32'h0000_2004});
      end
      dmem_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({dmem_req, dmem_be, st_ready, st_done, busy} !== {1'b0, 4'b0000, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rst_mid_abort actual=%b required=%b", {dmem_req, dmem_be, st_ready, st_done, busy}, {1'b0, 4'b0000, 1'b1, 1'b0, 1'b0});
      end
      @(negedge clk);
      checks++;
      if ({dmem_req, st_done} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_done actual=%b required=00", {dmem_req, st_done}); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_word_aligned();
      test_byte();
      test_half_split();
      test_stall_split();
      test_wrap();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_store_unit.md
# core_store_unit

Store-side data-memory interface for the core. It sits between the MEM stage and the data-memory port, on the write side of the path whose read side does size/sign extraction at writeback. It accepts one store per handshake and applies byte/half/word sizing. It generates byte enables and lane-shifted write data. A store that crosses a 32-bit word boundary is split into two aligned word writes, sequenced by a small FSM.

## Interface
- XLEN, 32, datapath and address width (only 32 supported)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_st_valid  in  1  MEM stage presents a store
- o_st_ready  out  1  unit can accept a store this cycle
- i_st_addr  in  XLEN  byte address of store
- i_st_data  in  XLEN  store data, right-justified
- i_st_size  in  2  00 byte, 01 half, 11 word, 10 treated as word
- o_busy  out  1  store in flight; pipeline stall source
- o_st_done  out  1  one-cycle pulse: store fully written
- o_dmem_req  out  1  write request to data memory
- i_dmem_gnt  in  1  memory accepts current request
- o_dmem_we  out  1  write enable, equals o_dmem_req
- o_dmem_addr  out  XLEN  word-aligned address, bits [1:0] always 00
- o_dmem_wdata  out  XLEN  lane-positioned write data
- o_dmem_be  out  4  byte enables, bit n selects byte lane n

## Operation
- FSM states: IDLE, FIRST, SECOND.
- o_st_ready = (state == IDLE). A store is accepted when i_st_valid & o_st_ready.
- On accept, compute the following and register them:
  - base mask: 0001 for byte, 0011 for half, 1111 for word/10
  - masked data: bits above the size are zeroed
  - 64-bit shifted data: masked data << (addr[1:0]*8)
  - 8-bit mask: base mask << addr[1:0]
  - low half of each → beat 0; high half → beat 1
  - split = (high mask != 0000)
- IDLE → FIRST on accept. The request is driven with addr[31:2],00, the low data and the low mask.
- FIRST, on gnt: go to SECOND if split, else go to IDLE.
- SECOND drives word address + 4 (mod 2^32, wraps to 0), the high data and the high mask. On gnt → IDLE.
- Handshake: once asserted, o_dmem_req stays high with addr/wdata/be stable until the cycle i_dmem_gnt is high. A beat completes only on req & gnt. Gnt while req is low is ignored.
- o_busy = (state != IDLE).
- No byte lane is ever written outside the sized range.

## Timing
- Reset values:
  - state IDLE
  - o_dmem_req / o_dmem_we 0
  - o_dmem_addr 0, o_dmem_wdata 0, o_dmem_be 0000
  - o_st_done 0, o_busy 0
  - o_st_ready 1 from the first cycle after reset.
- All o_dmem_* and o_st_done outputs are registered.
- Accept in cycle N → o_dmem_req high in N+1.
- Aligned store with immediate gnt: grant in N+1, o_st_done in N+2, o_st_ready high in N+2.
- Split store with immediate gnts: beats in N+1 and N+2, o_st_done in N+3.
- Each cycle of gnt low adds one cycle per beat.
- o_st_done and o_st_ready may both be high in the same cycle. A new store accepted then issues its request the next cycle, so back-to-back throughput is one aligned store per 2 cycles.
- Reset mid-operation (any state): request drops the next cycle, the pending beat is abandoned with no retry, and o_st_done is not pulsed.

## Structure
- Shared package core_pkg holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11
  - store FSM state enum
- One combinational sub-module, core_store_align: inputs addr[1:0], size, data; outputs 64-bit shifted data and 8-bit mask.
- The FSM and registers live in core_store_unit.

## Test plan
- Word 0x11223344 @0x1000, gnt tied high → one beat: addr 0x1000, be 1111, wdata 0x11223344; done 2 cycles after accept.
- Byte, data 0xDEADBEAB @0x1003 → one beat: addr 0x1000, be 1000, wdata 0xAB000000.
- Half 0xBEEF @0x2003 → beat 0: addr 0x2000, be 1000, wdata 0xEF000000. Beat 1: addr 0x2004, be 0001, wdata 0x000000BE. One done pulse.
- Word 0x11223344 @0x3001, gnt held low 3 cycles per beat → beat 0 (0x3000, 1110, 0x22334400) and beat 1 (0x3004, 0001, 0x00000011). Both stay stable while waiting; o_st_ready is low throughout.
- Half 0xCAFE @0xFFFFFFFF → beat 0: addr 0xFFFFFFFC, be 1000, wdata 0xFE000000. Beat 1 wraps: addr 0x00000000, be 0001, wdata 0x000000CA.
- Reset asserted while in SECOND with gnt low → next cycle req 0, be 0000, o_st_ready 1, no o_st_done pulse.
